// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch stage: drives the ROM address, gates the
// fetched instruction, selects the next PC from a writable jump-target LUT.
module fetch_unit #(
  parameter int              PC_W       = 8,
  parameter int              IW         = 9,
  parameter int              LUT_AW     = 4,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [IW-1:0]   HALT_OP    = 9'h1FF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Zero,
  input  logic [LUT_AW-1:0] TargetSel,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
  input  logic [IW-1:0]     InstIn,
  output logic [PC_W-1:0]   InstAddr,
  output logic [IW-1:0]     Instr,
  output logic              InstValid,
  output logic              Done,
  output logic [15:0]       CycleCount
);

  localparam int              LUT_N  = 2 ** LUT_AW;
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]     CC_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [15:0]     cc, cc_next;
  logic [PC_W-1:0] lut [LUT_N];
  logic [PC_W-1:0] target;
  logic            take_target;

  // Read before this edge's write lands, so a same-cycle write is seen one cycle later.
  assign target      = lut[TargetSel];
  assign take_target = Jump || (Branch && Zero);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    cc_next    = cc;
    case (state)
      IDLE: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = START_ADDR;
          cc_next    = '0;
        end
      end
      RUN: begin
        cc_next = (cc == CC_MAX) ? cc : cc + 16'd1;
        if (InstIn == HALT_OP) begin
          state_next = HALT;
        end else if (Stall) begin
          pc_next = pc;
        end else if (take_target) begin
          pc_next = target;
        end else begin
          pc_next = pc + PC_ONE;
        end
      end
      HALT: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = START_ADDR;
          cc_next    = '0;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = '0;
        cc_next    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc    <= '0;
      cc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      cc    <= cc_next;
    end
  end

  // NOTE: the LUT is small and must read as zero after reset, so it is built
  // from resettable flops rather than a RAM macro.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut[i] <= '0;
      end
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

  assign InstAddr   = pc;
  assign InstValid  = (state == RUN);
  assign Done       = (state == HALT);
  assign CycleCount = cc;
  assign Instr      = InstValid ? InstIn : '0;

endmodule
